// File: rtl/writeback.sv
// Final pipeline stage: commits execute results to the integer register file,
// tracks pending writers per register, raises redirect flushes and counts retirements.
module writeback #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2,
  parameter int RET_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_wen,
  input  logic [4:0]       res_rd,
  input  logic [XLEN-1:0]  res_value,
  input  logic             res_redirect,
  input  logic [XLEN-1:0]  res_target,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [4:0]       issue_rd,
  output logic             issue_ok,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [RET_W-1:0] retired
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0][XLEN-1:0]  regs_q, regs_d;
  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic [RET_W-1:0]       retired_q, retired_d;

  logic accept, wr, inc;

  // Results arriving during the flush cycle belong to squashed instructions.
  assign accept = res_valid & rst & ~flush_q;
  assign wr     = accept & res_wen & (res_rd != 5'd0);
  assign inc    = issue_valid & issue_wen & (issue_rd != 5'd0) & ~flush_q;

  assign res_ready   = 1'b1;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign retired     = retired_q;

  assign rs1_data = (rs1_addr == 5'd0) ? '0 :
                    (wr && res_rd == rs1_addr) ? res_value : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 :
                    (wr && res_rd == rs2_addr) ? res_value : regs_q[rs2_addr];

  // A last pending writer committing this cycle releases the register early,
  // matching the bypassed read data.
  assign rs1_busy = (rs1_addr != 5'd0) && (cnt_q[rs1_addr] != '0) &&
                    !(cnt_q[rs1_addr] == CNT_ONE && wr && res_rd == rs1_addr);
  assign rs2_busy = (rs2_addr != 5'd0) && (cnt_q[rs2_addr] != '0) &&
                    !(cnt_q[rs2_addr] == CNT_ONE && wr && res_rd == rs2_addr);

  assign issue_ok = (cnt_q[issue_rd] != CNT_MAX) || (issue_rd == 5'd0) || !issue_wen;

  always_comb begin
    regs_d        = regs_q;
    cnt_d         = cnt_q;
    flush_d       = accept & res_redirect;
    redirect_pc_d = redirect_pc_q;
    retired_d     = retired_q;
    if (wr) regs_d[res_rd] = res_value;
    if (accept) retired_d = retired_q + RET_W'(1);
    if (accept && res_redirect) redirect_pc_d = res_target;
    for (int i = 0; i < 32; i++) begin
      if (flush_q)
        cnt_d[i] = '0;
      else if (inc && issue_rd == 5'(i) && !(wr && res_rd == 5'(i)) && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (wr && res_rd == 5'(i) && !(inc && issue_rd == 5'(i)) && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q        <= '0;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      retired_q     <= '0;
    end else begin
      regs_q        <= regs_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      retired_q     <= retired_d;
    end
  end

  // Protocol checks on the decode/execute handshake.
  always_ff @(posedge clk) begin
    if (rst && !flush_q) begin
      assert (!(inc && !issue_ok))
        else $error("writeback: issue to saturated register x%0d", issue_rd);
      assert (!(wr && cnt_q[res_rd] == '0 && !(inc && issue_rd == res_rd)))
        else $error("writeback: write to x%0d with no pending writer", res_rd);
    end
  end
endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: bypass, scoreboard, redirect/flush, reset and counter wrap.
module tb_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, res_wen, res_redirect;
  logic [4:0]  res_rd;
  logic [31:0] res_value, res_target;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_rd;

  logic        res_ready, rs1_busy, rs2_busy, issue_ok, flush;
  logic [31:0] rs1_data, rs2_data, redirect_pc;
  logic [63:0] retired;

  logic        res_ready2, rs1_busy2, rs2_busy2, issue_ok2, flush2;
  logic [31:0] rs1_data2, rs2_data2, redirect_pc2;
  logic [2:0]  retired2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_wen(res_wen), .res_rd(res_rd), .res_value(res_value),
    .res_redirect(res_redirect), .res_target(res_target),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_ok(issue_ok),
    .flush(flush), .redirect_pc(redirect_pc), .retired(retired)
  );

  // Narrow retire counter so the wrap boundary is reachable in a short run.
  writeback #(.RET_W(3)) dut_w (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready2),
    .res_wen(res_wen), .res_rd(res_rd), .res_value(res_value),
    .res_redirect(res_redirect), .res_target(res_target),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data2), .rs2_data(rs2_data2),
    .rs1_busy(rs1_busy2), .rs2_busy(rs2_busy2), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_ok(issue_ok2),
    .flush(flush2), .redirect_pc(redirect_pc2), .retired(retired2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid = 0; res_wen = 0; res_redirect = 0; res_rd = 0;
    res_value = 0; res_target = 0;
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_wen = 1; issue_rd = rd;
  endtask

  task automatic result(input logic [4:0] rd, input logic wen, input logic [31:0] val);
    res_valid = 1; res_wen = wen; res_rd = rd; res_value = val;
  endtask

  initial begin
    idle();
    rs1_addr = 0; rs2_addr = 0;
    rst = 0;
    step(); step();
    rst = 1;
    #1;

    // Reset state
    rs1_addr = 5;
    #1;
    chk("rst_retired", retired, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
    chk("rst_res_ready", {63'd0, res_ready}, 64'd1);
    chk("rst_x5", {32'd0, rs1_data}, 64'd0);
    chk("rst_x5_busy", {63'd0, rs1_busy}, 64'd0);
    chk("rst_retired_narrow", {61'd0, retired2}, 64'd0);

    // Write x5 with bypass
    issue(5); step(); idle();
    chk("x5_busy_pending", {63'd0, rs1_busy}, 64'd1);
    result(5, 1, 32'hDEADBEEF);
    #1;
    chk("x5_bypass", {32'd0, rs1_data}, 64'hDEADBEEF);
    chk("x5_early_release", {63'd0, rs1_busy}, 64'd0);
    step(); idle(); #1;
    chk("x5_stored", {32'd0, rs1_data}, 64'hDEADBEEF);
    chk("x5_retired", retired, 64'd1);

    // Write to x0 is discarded but retires
    rs1_addr = 0;
    result(0, 1, 32'h1234);
    #1;
    chk("x0_bypass_blocked", {32'd0, rs1_data}, 64'd0);
    step(); idle(); #1;
    chk("x0_reads_zero", {32'd0, rs1_data}, 64'd0);
    chk("x0_busy", {63'd0, rs1_busy}, 64'd0);
    chk("x0_retired", retired, 64'd2);

    // Saturate x7 counter
    for (int k = 0; k < 3; k++) begin
      issue(7); #1;
      chk("x7_issue_ok_fill", {63'd0, issue_ok}, 64'd1);
      step();
    end
    idle();
    issue_wen = 1; issue_rd = 7; #1;
    chk("x7_saturated", {63'd0, issue_ok}, 64'd0);
    issue_wen = 0; #1;
    chk("x7_nonwriting_ok", {63'd0, issue_ok}, 64'd1);
    idle();
    rs1_addr = 7;
    result(7, 1, 32'h77); #1;
    chk("x7_busy_count3", {63'd0, rs1_busy}, 64'd1);
    step(); idle();
    issue_wen = 1; issue_rd = 7; #1;
    chk("x7_count2_ok", {63'd0, issue_ok}, 64'd1);
    chk("x7_count2_busy", {63'd0, rs1_busy}, 64'd1);
    chk("x7_retired", retired, 64'd3);
    // Simultaneous issue and write leaves the count at 2
    issue(7); result(7, 1, 32'h88);
    step(); idle();
    issue_wen = 1; issue_rd = 7; #1;
    chk("x7_same_cycle_ok", {63'd0, issue_ok}, 64'd1);
    chk("x7_data88", {32'd0, rs1_data}, 64'h88);
    issue(7); step(); idle();
    issue_wen = 1; issue_rd = 7; #1;
    chk("x7_back_to_3", {63'd0, issue_ok}, 64'd0);
    idle();

    // Early release on x9 via rs2
    rs2_addr = 9;
    issue(9); step(); idle(); #1;
    chk("x9_busy", {63'd0, rs2_busy}, 64'd1);
    result(9, 1, 32'h99); #1;
    chk("x9_release", {63'd0, rs2_busy}, 64'd0);
    chk("x9_bypass", {32'd0, rs2_data}, 64'h99);
    step(); idle(); #1;
    chk("x9_retired", retired, 64'd5);

    // Redirect from x1 write; flush-cycle result to x2 is dropped
    issue(1); step(); idle();
    result(1, 1, 32'h11); res_redirect = 1; res_target = 32'h80000040; #1;
    chk("redir_no_flush_yet", {63'd0, flush}, 64'd0);
    step(); idle();
    rs1_addr = 2; rs2_addr = 1;
    result(2, 1, 32'h22); res_redirect = 1; res_target = 32'h1000;
    issue(3);
    #1;
    chk("redir_flush", {63'd0, flush}, 64'd1);
    chk("redir_pc", {32'd0, redirect_pc}, 64'h80000040);
    chk("redir_x1", {32'd0, rs2_data}, 64'h11);
    chk("redir_retired", retired, 64'd6);
    chk("flush_drop_bypass", {32'd0, rs1_data}, 64'd0);
    step(); idle(); #1;
    chk("flush_one_cycle", {63'd0, flush}, 64'd0);
    chk("flush_x2_unchanged", {32'd0, rs1_data}, 64'd0);
    chk("flush_retired_same", retired, 64'd6);
    rs1_addr = 7; rs2_addr = 3; #1;
    chk("flush_clr_x7", {63'd0, rs1_busy}, 64'd0);
    chk("flush_clr_x3", {63'd0, rs2_busy}, 64'd0);
    issue_wen = 1; issue_rd = 7; #1;
    chk("flush_x7_ok", {63'd0, issue_ok}, 64'd1);
    idle();

    // Mid-stream reset with x3 pending and a redirect in flight
    issue(3); step(); issue(3); step(); idle(); #1;
    chk("x3_busy_pre_rst", {63'd0, rs2_busy}, 64'd1);
    result(0, 0, 32'h0); res_redirect = 1; res_target = 32'hCAFE0000;
    rst = 0; #1;
    chk("rst_ready_held", {63'd0, res_ready}, 64'd1);
    step(); idle(); #1;
    chk("rst2_flush", {63'd0, flush}, 64'd0);
    chk("rst2_redirect_pc", {32'd0, redirect_pc}, 64'd0);
    chk("rst2_retired", retired, 64'd0);
    chk("rst2_x3_busy", {63'd0, rs2_busy}, 64'd0);
    rs1_addr = 5; #1;
    chk("rst2_x5_cleared", {32'd0, rs1_data}, 64'd0);
    rst = 1;

    // Retire counter wrap on the narrow instance
    result(0, 0, 32'h0);
    for (int k = 0; k < 7; k++) step();
    chk("wrap_at_7", {61'd0, retired2}, 64'd7);
    step(); idle(); #1;
    chk("wrap_to_0", {61'd0, retired2}, 64'd0);
    chk("wide_at_8", retired, 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
